// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants and types for the P6 fetch stage:
//   PC_RESET_DEF  default reset PC, also the instruction ROM base address
//   IM_DEPTH_DEF  default ROM depth in 32-bit words (power of two)
//   NOP           all-zero instruction used for bubbles and out-of-range fetch
//   if_id_t       contents of the IF/ID pipeline register
//   align_word    clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int          IM_DEPTH_DEF = 4096;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } if_id_t;

  // Force a target address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_instr_rom.sv
// ---------------------------------------------------------------------------
// instr_rom
// Asynchronous instruction ROM with base-address offset and range check.
// Ports:
//   pc     in  32  byte address to fetch (word-aligned)
//   instr  out 32  ROM word at pc, or NOP when pc is outside the ROM window
// Parameters:
//   BASE     byte address of ROM word 0
//   DEPTH    number of 32-bit words (power of two)
//   CONTENT  ROM image, word 0 first
// ---------------------------------------------------------------------------
module instr_rom
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] BASE    = PC_RESET_DEF,
  parameter int          DEPTH   = IM_DEPTH_DEF,
  parameter logic [31:0] CONTENT [0:DEPTH-1] = '{default: NOP}
) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] ROM_BYTES = 32'(4 * DEPTH);

  logic [31:0]      offset_s;
  logic             in_range_s;
  logic [IDX_W-1:0] word_idx_s;

  // A single unsigned compare of the offset covers both ends of the window:
  // a pc below BASE wraps to a huge offset and fails the same test.
  assign offset_s   = pc - BASE;
  assign in_range_s = (offset_s < ROM_BYTES);
  assign word_idx_s = offset_s[IDX_W+1:2];

  // Combinational read, nop outside the ROM window.
  always_comb begin
    instr = NOP;
    if (in_range_s) begin
      instr = CONTENT[word_idx_s];
    end else begin
      instr = NOP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// IF stage plus IF/ID pipeline register of the P6 five-stage MIPS core.
// Ports:
//   clk          in   1   clock, all state updates on posedge
//   reset        in   1   synchronous active-high reset
//   stall        in   1   freeze PC and IF/ID
//   redirect     in   1   taken branch/jump resolved in D this cycle
//   redirect_pc  in   32  redirect target, bits [1:0] ignored
//   f_pc         out  32  current fetch PC
//   d_instr      out  32  registered instruction for the decoder
//   d_pc         out  32  PC of d_instr
//   d_pc8        out  32  d_pc + 8 (jal/jalr link value)
//   d_valid      out  1   0 only for the reset bubble
// Parameters:
//   PC_RESET  reset PC and ROM base address
//   IM_DEPTH  ROM depth in words (power of two)
//   IM_INIT   ROM image, word 0 at PC_RESET
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          IM_DEPTH = IM_DEPTH_DEF,
  parameter logic [31:0] IM_INIT [0:IM_DEPTH-1] = '{default: NOP}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid
);

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic [31:0] f_instr_s;
  if_id_t      if_id_r;

  instr_rom #(
    .BASE    (PC_RESET),
    .DEPTH   (IM_DEPTH),
    .CONTENT (IM_INIT)
  ) u_rom (
    .pc    (pc_r),
    .instr (f_instr_s)
  );

  // Next-PC select: stall beats redirect, so a redirect arriving during a
  // stall is dropped and must be re-asserted by D once the stall clears.
  always_comb begin
    next_pc_s = pc_r;
    if (stall) begin
      next_pc_s = pc_r;
    end else if (redirect) begin
      next_pc_s = align_word(redirect_pc);
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= PC_RESET;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // IF/ID register; redirect deliberately does not flush it (delay slot).
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_r <= '{instr: NOP, pc: 32'h0, pc8: 32'h0, valid: 1'b0};
    end else if (!stall) begin
      if_id_r <= '{instr: f_instr_s, pc: pc_r, pc8: pc_r + 32'd8, valid: 1'b1};
    end else begin
      if_id_r <= if_id_r;
    end
  end

  assign f_pc    = pc_r;
  assign d_instr = if_id_r.instr;
  assign d_pc    = if_id_r.pc;
  assign d_pc8   = if_id_r.pc8;
  assign d_valid = if_id_r.valid;

endmodule
